// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// 1-bit running XOR accumulator (clear > load > enable), folded through the
// same xor_gate cell used by the upstream parity generator.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);
    logic acc_q;
    logic acc_d;
    logic fold;

    xor_gate u_xor (
        .a (acc_q),
        .b (bit_i),
        .y (fold)
    );

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = 1'b0;
        end else if (load_i) begin
            acc_d = bit_i;
        end else if (en_i) begin
            acc_d = fold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame deserialiser with trailing parity check.
// Optional macro SERIAL_PARITY_ERR_COUNT_EN adds a saturating err_count output.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 parity_err,
    output logic                 busy
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    ,
    output logic [7:0]           err_count
`endif
);
    localparam int unsigned     CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic            ODD_L    = (ODD_PARITY != 0);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   perr_q, perr_d;
    logic                   acc;
    logic                   acc_clr, acc_load, acc_en;
    logic                   start;

    assign start = bit_valid && frame_start;

    parity_accum u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (acc_clr),
        .load_i  (acc_load),
        .en_i    (acc_en),
        .bit_i   (bit_in),
        .acc_o   (acc)
    );

    // A qualified frame_start wins in every state, giving resync and
    // back-to-back frames out of the same branch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        perr_d   = perr_q;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        acc_en   = 1'b0;
        if (start) begin
            state_d    = DATA;
            cnt_d      = CNT_W'(1);
            shift_d    = '0;
            shift_d[0] = bit_in;
            acc_load   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                DONE: state_d = IDLE;
                DATA: begin
                    if (bit_valid) begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shift_d[i] = bit_in;
                            end
                        end
                        acc_en = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        dout_d  = shift_q;
                        perr_d  = acc ^ bit_in ^ ODD_L;
                        acc_clr = 1'b1;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = dout_q;
    assign parity_err = perr_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q == DATA) || (state_q == PARITY);

`ifdef SERIAL_PARITY_ERR_COUNT_EN
    logic [7:0] errc_q, errc_d;

    always_comb begin
        errc_d = errc_q;
        if (done && perr_q && (errc_q != ERR_COUNT_MAX)) begin
            errc_d = errc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errc_q <= '0;
        end else begin
            errc_q <= errc_d;
        end
    end

    assign err_count = errc_q;
`endif

endmodule
